// File: rtl/seq_vedic_mult16_ctrl.sv
// Multi-cycle 16x16 unsigned multiplier: one shared 8x8 Vedic core, four partial products, 32-bit accumulator.
// Define APPROX_TRUNC_EN to skip the low-by-low partial product (approximate mode, one cycle shorter).

module eight_bit_vedic_multiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  // Urdhva-tiryakbhyam: 2x2 crosswise cells composed into 4x4, then 8x8
  function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
    logic t1, t2, t3, c1;
    t1 = x[1] & y[0];
    t2 = x[0] & y[1];
    t3 = x[1] & y[1];
    c1 = t1 & t2;
    return {t3 & c1, t3 ^ c1, t1 ^ t2, x[0] & y[0]};
  endfunction

  function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] p0, p1, p2, p3;
    p0 = {4'b0, vm2(x[1:0], y[1:0])};
    p1 = {4'b0, vm2(x[3:2], y[1:0])};
    p2 = {4'b0, vm2(x[1:0], y[3:2])};
    p3 = {4'b0, vm2(x[3:2], y[3:2])};
    return p0 + ((p1 + p2) << 2) + (p3 << 4);
  endfunction

  logic [15:0] q0, q1, q2, q3;

  always_comb begin
    q0 = {8'b0, vm4(a[3:0], b[3:0])};
    q1 = {8'b0, vm4(a[7:4], b[3:0])};
    q2 = {8'b0, vm4(a[3:0], b[7:4])};
    q3 = {8'b0, vm4(a[7:4], b[7:4])};
    p  = q0 + ((q1 + q2) << 4) + (q3 << 8);
  end
endmodule

module seq_vedic_mult16_ctrl #(
  parameter int MUL_REG = 0,
  parameter int OP_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in1,
  input  logic [OP_W-1:0]   in2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OP_W-1:0] out,
  output logic              busy
);
  if (OP_W != 16) begin : g_op_w_chk
    $error("seq_vedic_mult16_ctrl: OP_W must be 16");
  end

  typedef enum logic [2:0] {S_IDLE, S_PP0, S_PP1, S_PP2, S_PP3, S_DRAIN, S_DONE} state_t;

`ifdef APPROX_TRUNC_EN
  localparam state_t FIRST = S_PP1;
`else
  localparam state_t FIRST = S_PP0;
`endif

  state_t            state_q, state_d;
  logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic [31:0]       acc_q, acc_d, out_q, out_d;
  logic [15:0]       prod_q, prod_d;
  logic [4:0]        sh_q, sh_d;
  logic              pend_q, pend_d;
  logic              ov_q, ov_d, in_ready_q, in_ready_d, busy_q, busy_d;

  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_p;
  logic [4:0]  cur_sh;
  logic [31:0] add_term;

  eight_bit_vedic_multiplier u_mul (.a(mul_a), .b(mul_b), .p(mul_p));

  // Operand halves and weight for the partial product owned by the current state
  always_comb begin
    mul_a  = (state_q == S_PP0 || state_q == S_PP2) ? a_q[7:0] : a_q[15:8];
    mul_b  = (state_q == S_PP0 || state_q == S_PP1) ? b_q[7:0] : b_q[15:8];
    cur_sh = (state_q == S_PP0) ? 5'd0 : (state_q == S_PP3) ? 5'd16 : 5'd8;
    if (MUL_REG != 0)
      add_term = pend_q ? ({16'b0, prod_q} << sh_q) : 32'd0;
    else
      add_term = {16'b0, mul_p} << cur_sh;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out_d   = out_q;
    prod_d  = prod_q;
    sh_d    = sh_q;
    pend_d  = pend_q;
    ov_d    = ov_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in1;
          b_d     = in2;
          acc_d   = 32'd0;
          pend_d  = 1'b0;
          state_d = FIRST;
        end
      end
      S_PP0, S_PP1, S_PP2, S_PP3: begin
        acc_d  = acc_q + add_term;
        prod_d = mul_p;
        sh_d   = cur_sh;
        pend_d = 1'b1;
        case (state_q)
          S_PP0:   state_d = S_PP1;
          S_PP1:   state_d = S_PP2;
          S_PP2:   state_d = S_PP3;
          default: begin
            if (MUL_REG != 0) begin
              state_d = S_DRAIN;
            end else begin
              state_d = S_DONE;
              out_d   = acc_d;
              ov_d    = 1'b1;
            end
          end
        endcase
      end
      S_DRAIN: begin
        acc_d   = acc_q + add_term;
        out_d   = acc_d;
        ov_d    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= 32'd0;
      out_q      <= 32'd0;
      prod_q     <= 16'd0;
      sh_q       <= 5'd0;
      pend_q     <= 1'b0;
      ov_q       <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      out_q      <= out_d;
      prod_q     <= prod_d;
      sh_q       <= sh_d;
      pend_q     <= pend_d;
      ov_q       <= ov_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = ov_q;
  assign out       = out_q;
endmodule

// File: tb/tb_seq_vedic_mult16_ctrl.sv
// Scoreboard bench: two instances (MUL_REG=0 and MUL_REG=1) share stimulus; a negedge monitor checks results and latency.
module tb_seq_vedic_mult16_ctrl;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [15:0] in1, in2;
  logic        in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1;
  logic [31:0] out0, out1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int acc_cyc[2];
  int exp_lat[2];
  logic prev_v[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  seq_vedic_mult16_ctrl #(.MUL_REG(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in1(in1), .in2(in2),
    .out_valid(out_valid0), .out_ready(out_ready), .out(out0), .busy(busy0));

  seq_vedic_mult16_ctrl #(.MUL_REG(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in1(in1), .in2(in2),
    .out_valid(out_valid1), .out_ready(out_ready), .out(out1), .busy(busy1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mon(input int i, input logic ir, input logic ov, input logic [31:0] o);
    logic [31:0] e;
    int sz;
    if (in_valid && ir) acc_cyc[i] = cyc + 1;
    if (ov && !prev_v[i]) chk($sformatf("latency%0d", i), cyc - acc_cyc[i], exp_lat[i]);
    prev_v[i] = ov;
    if (ov && out_ready) begin
      sz = (i == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out%0d got %h expected no output", i, o);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("product%0d", i), o, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_v[0] = 1'b0;
      prev_v[1] = 1'b0;
    end else begin
      mon(0, in_ready0, out_valid0, out0);
      mon(1, in_ready1, out_valid1, out1);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!(in_ready0 && in_ready1) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(in_ready0 && in_ready1)) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [31:0] e);
    wait_idle();
    in1 = a; in2 = b; in_valid = 1'b1;
    q0.push_back(e);
    q1.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // {in1, in2, exact product, approx product}
  localparam int NV = 6;
  logic [15:0] va[NV] = '{16'h1234, 16'hFFFF, 16'h00FF, 16'h00FF, 16'h0000, 16'h8001};
  logic [15:0] vb[NV] = '{16'h5678, 16'hFFFF, 16'h0100, 16'h00FF, 16'h1234, 16'h0003};
  logic [31:0] ve[NV] = '{32'h06260060, 32'hFFFE0001, 32'h0000FF00, 32'h0000FE01, 32'h0, 32'h00018003};
  logic [31:0] vt[NV] = '{32'h0625E800, 32'hFFFD0200, 32'h0000FF00, 32'h00000000, 32'h0, 32'h00018000};

  function automatic logic [31:0] pick(input logic [31:0] exact, input logic [31:0] approx);
`ifdef APPROX_TRUNC_EN
    return approx;
`else
    return exact;
`endif
  endfunction

  initial begin
`ifdef APPROX_TRUNC_EN
    exp_lat[0] = 3; exp_lat[1] = 4;
`else
    exp_lat[0] = 4; exp_lat[1] = 5;
`endif
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in1 = 16'h0; in2 = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out0", out0, 32'd0);
    chk("rst_ov0", {31'd0, out_valid0}, 32'd0);
    chk("rst_busy0", {31'd0, busy0}, 32'd0);
    chk("rst_ir0", {31'd0, in_ready0}, 32'd1);
    chk("rst_out1", out1, 32'd0);
    chk("rst_ov1", {31'd0, out_valid1}, 32'd0);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_ir1", {31'd0, in_ready1}, 32'd1);
    rst = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < NV; i++) issue(va[i], vb[i], pick(ve[i], vt[i]));

    // Operand pulses while busy must not disturb the running product
    issue(16'h0102, 16'h0304, pick(32'h00030A08, 32'h00030A00));
    @(posedge clk); #1;
    in1 = 16'hAAAA; in2 = 16'h5555; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;

    // Output backpressure
    wait_idle();
    out_ready = 1'b0;
    issue(16'hABCD, 16'h0010, pick(32'h000ABCD0, 32'h000AB000));
    for (int n = 0; n < 50 && !(out_valid0 && out_valid1); n++) begin
      @(posedge clk); #1;
    end
    chk("bp_valid_seen", {30'd0, out_valid0, out_valid1}, 32'd3);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_out0", out0, pick(32'h000ABCD0, 32'h000AB000));
      chk("bp_ov0", {31'd0, out_valid0}, 32'd1);
      chk("bp_ir0", {31'd0, in_ready0}, 32'd0);
      chk("bp_out1", out1, pick(32'h000ABCD0, 32'h000AB000));
      chk("bp_ov1", {31'd0, out_valid1}, 32'd1);
      chk("bp_ir1", {31'd0, in_ready1}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ir", {30'd0, in_ready0, in_ready1}, 32'd3);
    chk("bp_release_ov", {30'd0, out_valid0, out_valid1}, 32'd0);

    // Reset abort while the MUL_REG=0 instance is in PP2
    issue(16'h1111, 16'h2222, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
    chk("abort_ov", {30'd0, out_valid0, out_valid1}, 32'd0);
    chk("abort_ir", {30'd0, in_ready0, in_ready1}, 32'd3);
    chk("abort_out0", out0, 32'd0);
    chk("abort_out1", out1, 32'd0);
    repeat (8) @(posedge clk);
    #1;

    issue(16'hFFFF, 16'h0001, pick(32'h0000FFFF, 32'h0000FF00));
    for (int n = 0; n < 50 && (q0.size() != 0 || q1.size() != 0); n++) begin
      @(posedge clk); #1;
    end
    chk("drain_q0", q0.size(), 32'd0);
    chk("drain_q1", q1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
